// File: rtl/rv32_mod_lsu_sequencer.sv
// rv32_mod_lsu_sequencer
// -----------------------------------------------------------------------------
// Sequences a single RV32 load or store onto a simple request/acknowledge
// memory bus and returns an extended load result or a fault to the pipeline.
//
// Optional feature: define RV32_LSU_TIMEOUT_EN to add an 8-bit bus timeout.
// Without it, a BUS transfer waits indefinitely for bus_ack / bus_err.
//
// Ports
//   clk, rst            clock (rising edge), synchronous active-high reset
//   start               memory op present; held by the pipeline until done
//   ram_req[3:0]        [1:0] width (00 byte, 01 half, 10 word, 11 invalid),
//                       [2] unsigned load, [3] unused
//   ram_wr              1 = store, 0 = load
//   addr, wdata         effective byte address, right-aligned store data
//   stall               hold the pipeline (combinational)
//   done                one-cycle completion pulse
//   load_data, fault,   result and status, nonzero only while done
//   fault_cause         01 misaligned/invalid, 10 bus error, 11 timeout
//   bus_req, bus_we,    bus request, driven only while the transfer is open
//   bus_addr, bus_be,
//   bus_wdata
//   bus_ack, bus_err,   bus response; bus_err wins over bus_ack
//   bus_rdata
//   dbg_state           current FSM state (0 IDLE, 1 BUS, 2 RESP)
//
// Bus handshake: a transfer is open while bus_req=1. Every bus output holds
// its value from the first request cycle until the cycle in which the bus
// returns bus_ack or bus_err (sampled on the rising edge); bus_req drops in the
// following cycle.
// -----------------------------------------------------------------------------
module rv32_mod_lsu_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  ram_req,
    input  logic        ram_wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] load_data,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic        bus_err,
    input  logic [31:0] bus_rdata,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  req_q, req_d;
    logic        wr_q, wr_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        fault_q, fault_d;
    logic [1:0]  cause_q, cause_d;
    logic [31:0] ldata_q, ldata_d;
`ifdef RV32_LSU_TIMEOUT_EN
    logic [7:0]  cnt_q, cnt_d;
`endif

    // ram_req[3] carries no meaning for this unit.
    logic unused_req_bit;
    assign unused_req_bit = ram_req[3];

    logic        aligned;
    logic [31:0] shifted;
    logic [31:0] ext_data;

    // Width 11 is never aligned, so it falls into the misaligned fault path.
    always_comb begin
        aligned = 1'b0;
        case (ram_req[1:0])
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~addr[0];
            2'b10:   aligned = (addr[1:0] == 2'b00);
            default: aligned = 1'b0;
        endcase
    end

    // Move the addressed lane down to bit 0, then extend to 32 bits.
    always_comb begin
        shifted  = bus_rdata >> {addr_q[1:0], 3'b000};
        ext_data = shifted;
        case (req_q[1:0])
            2'b00:   ext_data = {{24{~req_q[2] & shifted[7]}}, shifted[7:0]};
            2'b01:   ext_data = {{16{~req_q[2] & shifted[15]}}, shifted[15:0]};
            default: ext_data = shifted;
        endcase
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        fault_d = fault_q;
        cause_d = cause_q;
        ldata_d = ldata_q;
`ifdef RV32_LSU_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (aligned) begin
                        req_d   = ram_req[2:0];
                        wr_d    = ram_wr;
                        addr_d  = addr;
                        wdata_d = wdata;
                        state_d = BUS;
`ifdef RV32_LSU_TIMEOUT_EN
                        cnt_d   = 8'd0;
`endif
                    end else begin
                        fault_d = 1'b1;
                        cause_d = 2'b01;
                        ldata_d = 32'd0;
                        state_d = RESP;
                    end
                end
            end
            BUS: begin
                if (bus_err) begin
                    fault_d = 1'b1;
                    cause_d = 2'b10;
                    ldata_d = 32'd0;
                    state_d = RESP;
                end else if (bus_ack) begin
                    fault_d = 1'b0;
                    cause_d = 2'b00;
                    ldata_d = wr_q ? 32'd0 : ext_data;
                    state_d = RESP;
                end
`ifdef RV32_LSU_TIMEOUT_EN
                // cnt_q counts unanswered BUS cycles; the 256th gives up.
                else if (cnt_q == 8'hFF) begin
                    fault_d = 1'b1;
                    cause_d = 2'b11;
                    ldata_d = 32'd0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            RESP: begin
                fault_d = 1'b0;
                cause_d = 2'b00;
                ldata_d = 32'd0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= 3'd0;
            wr_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            fault_q <= 1'b0;
            cause_q <= 2'b00;
            ldata_q <= 32'd0;
`ifdef RV32_LSU_TIMEOUT_EN
            cnt_q   <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            fault_q <= fault_d;
            cause_q <= cause_d;
            ldata_q <= ldata_d;
`ifdef RV32_LSU_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    logic in_bus;
    logic in_resp;
    assign in_bus  = (state_q == BUS);
    assign in_resp = (state_q == RESP);

    assign stall     = ((state_q == IDLE) && start) || in_bus;
    assign done      = in_resp;
    assign fault     = in_resp & fault_q;
    assign fault_cause = in_resp ? cause_q : 2'b00;
    assign load_data = in_resp ? ldata_q : 32'd0;
    assign dbg_state = state_q;

    assign bus_req  = in_bus;
    assign bus_we   = in_bus & wr_q;
    assign bus_addr = in_bus ? {addr_q[31:2], 2'b00} : 32'd0;

    always_comb begin
        bus_be    = 4'b0000;
        bus_wdata = 32'd0;
        if (in_bus) begin
            case (req_q[1:0])
                2'b00: begin
                    bus_be    = 4'b0001 << addr_q[1:0];
                    bus_wdata = {4{wdata_q[7:0]}};
                end
                2'b01: begin
                    bus_be    = 4'b0011 << addr_q[1:0];
                    bus_wdata = {2{wdata_q[15:0]}};
                end
                default: begin
                    bus_be    = 4'b1111;
                    bus_wdata = wdata_q;
                end
            endcase
        end
    end

endmodule
